// File: rtl/lrn_pkg.sv
// Shared types for the LRN padding unit: FSM state encoding and the zero word
// written to every border location.
package lrn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } pad_state_t;

   localparam int PAD_DATA_WIDTH = 16;
   localparam logic [PAD_DATA_WIDTH-1:0] PAD_ZERO = '0;

endpackage

// File: rtl/lrn_pad_index_gen.sv
// Border-address walker: h innermost, then w, m, n. Interior columns jump
// straight over the mapper-written rows so every step lands on a border word.
module lrn_pad_index_gen #(
   parameter int N_WIDTH        = 2,
   parameter int M_WIDTH        = 10,
   parameter int E_WIDTH        = 6,
   parameter int F_WIDTH        = 6,
   parameter int V_WIDTH        = 2,
   parameter int ADDR_BUS_WIDTH = 20
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       clear_i,
   input  logic                       step_i,
   input  logic [N_WIDTH-1:0]         dim4_i,
   input  logic [M_WIDTH-1:0]         dim3_i,
   input  logic [E_WIDTH-1:0]         dim2_i,
   input  logic [F_WIDTH-1:0]         dim1_i,
   input  logic [V_WIDTH-1:0]         pad_i,
   input  logic [E_WIDTH-1:0]         p2_i,
   input  logic [F_WIDTH-1:0]         p1_i,
   input  logic [E_WIDTH+F_WIDTH-1:0] plane_i,
   output logic [ADDR_BUS_WIDTH-1:0]  addr_o,
   output logic                       last_o
);

   localparam logic [N_WIDTH-1:0] N_ONE = 1;
   localparam logic [M_WIDTH-1:0] M_ONE = 1;
   localparam logic [E_WIDTH-1:0] E_ONE = 1;
   localparam logic [F_WIDTH-1:0] F_ONE = 1;

   logic [E_WIDTH-1:0] h_q, h_d;
   logic [F_WIDTH-1:0] w_q, w_d;
   logic [M_WIDTH-1:0] m_q, m_d;
   logic [N_WIDTH-1:0] n_q, n_d;
   logic [ADDR_BUS_WIDTH-1:0] plane_base_q, plane_base_d;
   logic [ADDR_BUS_WIDTH-1:0] col_base_q, col_base_d;
   logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;

   logic [E_WIDTH-1:0] pad_e, h_hi;
   logic [F_WIDTH-1:0] pad_f, w_hi;
   logic interior_col, last_h, last_w, last_m, last_n;

   always_comb begin
      pad_e        = E_WIDTH'(pad_i);
      pad_f        = F_WIDTH'(pad_i);
      h_hi         = dim2_i + pad_e;
      w_hi         = dim1_i + pad_f;
      interior_col = (w_q >= pad_f) && (w_q < w_hi);
      last_h       = (h_q == p2_i - E_ONE);
      last_w       = (w_q == p1_i - F_ONE);
      last_m       = (m_q == dim3_i - M_ONE);
      last_n       = (n_q == dim4_i - N_ONE);

      h_d          = h_q;
      w_d          = w_q;
      m_d          = m_q;
      n_d          = n_q;
      plane_base_d = plane_base_q;
      col_base_d   = col_base_q;

      if (interior_col && (h_q == pad_e - E_ONE)) begin
         h_d = h_hi;
      end else if (last_h) begin
         h_d = '0;
         if (last_w) begin
            w_d          = '0;
            col_base_d   = '0;
            plane_base_d = plane_base_q + ADDR_BUS_WIDTH'(plane_i);
            if (last_m) begin
               m_d = '0;
               n_d = n_q + N_ONE;
            end else begin
               m_d = m_q + M_ONE;
            end
         end else begin
            w_d        = w_q + F_ONE;
            col_base_d = col_base_q + ADDR_BUS_WIDTH'(p2_i);
         end
      end else begin
         h_d = h_q + E_ONE;
      end

      addr_d = plane_base_d + col_base_d + ADDR_BUS_WIDTH'(h_d);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || clear_i) begin
         h_q          <= '0;
         w_q          <= '0;
         m_q          <= '0;
         n_q          <= '0;
         plane_base_q <= '0;
         col_base_q   <= '0;
         addr_q       <= '0;
      end else if (step_i) begin
         h_q          <= h_d;
         w_q          <= w_d;
         m_q          <= m_d;
         n_q          <= n_d;
         plane_base_q <= plane_base_d;
         col_base_q   <= col_base_d;
         addr_q       <= addr_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = last_n && last_m && last_w && last_h;

endmodule

// File: rtl/unsigned_wallace_tree_multiplier.sv
// Unsigned combinational multiplier built from AND partial products reduced
// with 3:2 carry-save compressors and one final carry-propagate adder.
module unsigned_wallace_tree_multiplier #(
   parameter int A_WIDTH = 6,
   parameter int B_WIDTH = 6
) (
   input  logic [A_WIDTH-1:0]         a_i,
   input  logic [B_WIDTH-1:0]         b_i,
   output logic [A_WIDTH+B_WIDTH-1:0] product_o
);

   localparam int P_WIDTH = A_WIDTH + B_WIDTH;

   logic [P_WIDTH-1:0] sum_v;
   logic [P_WIDTH-1:0] carry_v;
   logic [P_WIDTH-1:0] pp_v;
   logic [P_WIDTH-1:0] tmp_v;

   always_comb begin
      sum_v   = '0;
      carry_v = '0;
      pp_v    = '0;
      tmp_v   = '0;
      for (int j = 0; j < B_WIDTH; j++) begin
         pp_v    = {{B_WIDTH{1'b0}}, a_i & {A_WIDTH{b_i[j]}}} << j;
         tmp_v   = sum_v ^ carry_v ^ pp_v;
         carry_v = ((sum_v & carry_v) | (sum_v & pp_v) | (carry_v & pp_v)) << 1;
         sum_v   = tmp_v;
      end
      product_o = sum_v + carry_v;
   end

endmodule

// File: rtl/lrn_padding_unit.sv
// Zero-fills the border of the padded LRN output tensor in the GLB after the
// mapper has written the interior, then pulses padding_done.
//
// state | meaning
// IDLE  | waiting for start_padding; dims latched on start
// SETUP | padded sizes computed, walker cleared, zero-work check
// WRITE | one border word per accepted cycle
// DONE  | padding_done high for this single cycle
module lrn_padding_unit
   import lrn_pkg::*;
#(
   parameter int N_WIDTH        = 2,
   parameter int M_WIDTH        = 10,
   parameter int E_WIDTH        = 6,
   parameter int F_WIDTH        = 6,
   parameter int V_WIDTH        = 2,
   parameter int ADDR_BUS_WIDTH = 20,
   parameter int DATA_WIDTH     = PAD_DATA_WIDTH
) (
   input  logic                      core_clk,
   input  logic                      reset,
   input  logic                      start_padding,
   input  logic [N_WIDTH-1:0]        dim4,
   input  logic [M_WIDTH-1:0]        dim3,
   input  logic [E_WIDTH-1:0]        dim2,
   input  logic [F_WIDTH-1:0]        dim1,
   input  logic [V_WIDTH-1:0]        padding_num,
   input  logic                      w_ready,
   output logic [ADDR_BUS_WIDTH-1:0] w_addr,
   output logic [DATA_WIDTH-1:0]     w_data,
   output logic                      w_enable,
   output logic                      busy,
   output logic                      padding_done
);

   pad_state_t state_q;
   logic [N_WIDTH-1:0] dim4_q;
   logic [M_WIDTH-1:0] dim3_q;
   logic [E_WIDTH-1:0] dim2_q, p2_q, p2_calc;
   logic [F_WIDTH-1:0] dim1_q, p1_q, p1_calc;
   logic [V_WIDTH-1:0] pad_q;
   logic               w_enable_q, busy_q, done_q;
   logic [E_WIDTH+F_WIDTH-1:0] plane;
   logic               last, step, clear;

   assign p2_calc = dim2_q + E_WIDTH'({pad_q, 1'b0});
   assign p1_calc = dim1_q + F_WIDTH'({pad_q, 1'b0});
   assign step    = (state_q == WRITE) && w_ready;
   assign clear   = (state_q == SETUP);

   unsigned_wallace_tree_multiplier #(
      .A_WIDTH(F_WIDTH),
      .B_WIDTH(E_WIDTH)
   ) u_plane_mul (
      .a_i      (p1_q),
      .b_i      (p2_q),
      .product_o(plane)
   );

   lrn_pad_index_gen #(
      .N_WIDTH       (N_WIDTH),
      .M_WIDTH       (M_WIDTH),
      .E_WIDTH       (E_WIDTH),
      .F_WIDTH       (F_WIDTH),
      .V_WIDTH       (V_WIDTH),
      .ADDR_BUS_WIDTH(ADDR_BUS_WIDTH)
   ) u_index_gen (
      .clk_i  (core_clk),
      .reset_i(reset),
      .clear_i(clear),
      .step_i (step),
      .dim4_i (dim4_q),
      .dim3_i (dim3_q),
      .dim2_i (dim2_q),
      .dim1_i (dim1_q),
      .pad_i  (pad_q),
      .p2_i   (p2_q),
      .p1_i   (p1_q),
      .plane_i(plane),
      .addr_o (w_addr),
      .last_o (last)
   );

   always_ff @(posedge core_clk) begin
      if (reset) begin
         state_q    <= IDLE;
         dim4_q     <= '0;
         dim3_q     <= '0;
         dim2_q     <= '0;
         dim1_q     <= '0;
         pad_q      <= '0;
         p1_q       <= '0;
         p2_q       <= '0;
         w_enable_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_padding) begin
                  dim4_q  <= dim4;
                  dim3_q  <= dim3;
                  dim2_q  <= dim2;
                  dim1_q  <= dim1;
                  pad_q   <= padding_num;
                  busy_q  <= 1'b1;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               p1_q <= p1_calc;
               p2_q <= p2_calc;
               if (pad_q == '0 || dim3_q == '0 || dim4_q == '0) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  w_enable_q <= 1'b1;
                  state_q    <= WRITE;
               end
            end
            WRITE: begin
               if (w_ready && last) begin
                  w_enable_q <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign w_data       = DATA_WIDTH'(PAD_ZERO);
   assign w_enable     = w_enable_q;
   assign busy         = busy_q;
   assign padding_done = done_q;

endmodule

// File: tb/tb_lrn_padding_unit.sv
// Scoreboard bench for lrn_padding_unit: stimulus pushes expected border
// addresses, a negedge monitor pops and compares every accepted write.
module tb_lrn_padding_unit;

   logic        core_clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_padding = 1'b0;
   logic [1:0]  dim4 = '0;
   logic [9:0]  dim3 = '0;
   logic [5:0]  dim2 = '0;
   logic [5:0]  dim1 = '0;
   logic [1:0]  padding_num = '0;
   logic        w_ready = 1'b1;
   logic [19:0] w_addr;
   logic [15:0] w_data;
   logic        w_enable;
   logic        busy;
   logic        padding_done;

   lrn_padding_unit dut (
      .core_clk     (core_clk),
      .reset        (reset),
      .start_padding(start_padding),
      .dim4         (dim4),
      .dim3         (dim3),
      .dim2         (dim2),
      .dim1         (dim1),
      .padding_num  (padding_num),
      .w_ready      (w_ready),
      .w_addr       (w_addr),
      .w_data       (w_data),
      .w_enable     (w_enable),
      .busy         (busy),
      .padding_done (padding_done)
   );

   always #5 core_clk = ~core_clk;

   int cyc = 0;
   always @(posedge core_clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   int writes_seen, done_cnt, done_rel, busy_cycles, start_cyc, first_we_rel;
   int ready_mode = 0;
   logic [19:0] exp_q[$];
   logic [19:0] last_addr, addr_idx48;
   int T1_ADDR[12] = '{0, 1, 2, 3, 4, 7, 8, 11, 12, 13, 14, 15};

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // w_ready driver: tied high, or the 1,0,0 repeating pattern
   initial begin
      int k = 0;
      forever begin
         @(posedge core_clk);
         #1;
         if (ready_mode == 1) begin
            w_ready = (k % 3 == 0);
            k++;
         end else begin
            w_ready = 1'b1;
         end
      end
   end

   // monitor / scoreboard
   initial begin
      logic        prev_stall;
      logic [19:0] prev_addr;
      logic [19:0] e;
      prev_stall = 1'b0;
      prev_addr  = '0;
      forever begin
         @(negedge core_clk);
         if (prev_stall) begin
            checks++;
            if (w_addr !== prev_addr || w_enable !== 1'b1) begin
               failures++;
               $display("FAIL hold_stall actual addr=%0d en=%0b expected addr=%0d en=1",
                        w_addr, w_enable, prev_addr);
            end
         end
         if (w_enable && w_ready) begin
            writes_seen++;
            last_addr = w_addr;
            if (writes_seen == 49) addr_idx48 = w_addr;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write actual addr=%0d expected no write", w_addr);
            end else begin
               e = exp_q.pop_front();
               if (w_addr !== e || w_data !== 16'h0) begin
                  failures++;
                  $display("FAIL write_word actual addr=%0d data=%0h expected addr=%0d data=0",
                           w_addr, w_data, e);
               end
            end
         end
         if (w_enable && first_we_rel < 0) first_we_rel = cyc - start_cyc + 1;
         prev_stall = w_enable && !w_ready;
         prev_addr  = w_addr;
         if (padding_done) begin
            done_cnt++;
            done_rel = cyc - start_cyc + 1;
         end
         if (busy) busy_cycles++;
      end
   end

   task automatic clear_stats();
      writes_seen  = 0;
      done_cnt     = 0;
      done_rel     = -1;
      busy_cycles  = 0;
      first_we_rel = -1;
   endtask

   task automatic start_run(input int n, input int m, input int e, input int f, input int p);
      @(posedge core_clk);
      #1;
      clear_stats();
      dim4          = 2'(n);
      dim3          = 10'(m);
      dim2          = 6'(e);
      dim1          = 6'(f);
      padding_num   = 2'(p);
      start_padding = 1'b1;
      @(posedge core_clk);
      #1;
      start_padding = 1'b0;
      start_cyc     = cyc;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge core_clk);
         #1;
         n++;
      end
      if (done_cnt == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_done expected=done within %0d cycles", name, budget);
      end
      repeat (5) @(negedge core_clk);
      #1;
   endtask

   task automatic push_t1();
      for (int i = 0; i < 12; i++) exp_q.push_back(20'(T1_ADDR[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int waited;
      clear_stats();
      repeat (3) @(posedge core_clk);
      @(negedge core_clk);
      check_int("rst_w_enable", int'(w_enable), 0);
      check_int("rst_w_addr", int'(w_addr), 0);
      check_int("rst_w_data", int'(w_data), 0);
      check_int("rst_busy", int'(busy), 0);
      check_int("rst_done", int'(padding_done), 0);
      @(posedge core_clk);
      #1 reset = 1'b0;

      // 1x1x2x2 with p=1
      push_t1();
      start_run(1, 1, 2, 2, 1);
      wait_done("t1", 60);
      check_int("t1_writes", writes_seen, 12);
      check_int("t1_first_we_cycle", first_we_rel, 2);
      check_int("t1_done_cycle", done_rel, 14);
      check_int("t1_done_pulses", done_cnt, 1);
      check_int("t1_queue_left", exp_q.size(), 0);

      // N=2, M=3, 4x4, p=2: padded 8x8 planes of 64
      for (int n = 0; n < 2; n++)
         for (int m = 0; m < 3; m++)
            for (int w = 0; w < 8; w++)
               for (int h = 0; h < 8; h++)
                  if (h < 2 || h >= 6 || w < 2 || w >= 6)
                     exp_q.push_back(20'((n * 3 + m) * 64 + w * 8 + h));
      start_run(2, 3, 4, 4, 2);
      wait_done("t2", 400);
      check_int("t2_writes", writes_seen, 288);
      check_int("t2_done_cycle", done_rel, 290);
      check_int("t2_plane1_base", int'(addr_idx48), 64);
      check_int("t2_last_addr", int'(last_addr), 383);
      check_int("t2_queue_left", exp_q.size(), 0);

      // back-pressure
      ready_mode = 1;
      push_t1();
      start_run(1, 1, 2, 2, 1);
      wait_done("t3", 100);
      ready_mode = 0;
      check_int("t3_writes", writes_seen, 12);
      check_int("t3_done_pulses", done_cnt, 1);
      check_int("t3_queue_left", exp_q.size(), 0);

      // p=0: nothing to write
      start_run(1, 1, 2, 2, 0);
      wait_done("t4", 20);
      check_int("t4_writes", writes_seen, 0);
      check_int("t4_done_cycle", done_rel, 2);
      check_int("t4_busy_cycles", busy_cycles, 1);
      check_int("t4_done_pulses", done_cnt, 1);

      // reset on the 5th write
      push_t1();
      start_run(1, 1, 2, 2, 1);
      waited = 0;
      while (writes_seen < 5 && waited < 40) begin
         @(negedge core_clk);
         #1;
         waited++;
      end
      check_int("t5_reached_5th_write", writes_seen, 5);
      reset = 1'b1;
      @(negedge core_clk);
      check_int("t5_rst_w_enable", int'(w_enable), 0);
      check_int("t5_rst_w_addr", int'(w_addr), 0);
      check_int("t5_rst_busy", int'(busy), 0);
      check_int("t5_rst_done", int'(padding_done), 0);
      @(posedge core_clk);
      #1 reset = 1'b0;
      exp_q.delete();
      repeat (20) @(negedge core_clk);
      #1;
      check_int("t5_no_done_after_abort", done_cnt, 0);
      check_int("t5_no_write_after_abort", int'(w_enable), 0);
      push_t1();
      start_run(1, 1, 2, 2, 1);
      wait_done("t5_restart", 60);
      check_int("t5_restart_writes", writes_seen, 12);
      check_int("t5_restart_done_cycle", done_rel, 14);
      check_int("t5_queue_left", exp_q.size(), 0);

      // spurious start during WRITE, with changed dims that must be ignored
      push_t1();
      start_run(1, 1, 2, 2, 1);
      waited = 0;
      while (writes_seen < 3 && waited < 40) begin
         @(negedge core_clk);
         #1;
         waited++;
      end
      @(posedge core_clk);
      #1;
      dim2          = 6'd5;
      dim1          = 6'd3;
      start_padding = 1'b1;
      @(posedge core_clk);
      #1 start_padding = 1'b0;
      wait_done("t6", 60);
      repeat (10) @(negedge core_clk);
      check_int("t6_writes", writes_seen, 12);
      check_int("t6_done_pulses", done_cnt, 1);
      check_int("t6_done_cycle", done_rel, 14);
      check_int("t6_queue_left", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lrn_padding_unit.md
Name: lrn_padding_unit

Overview:
- Downstream neighbour of the LRN mapper. When the mapper raises normalized_layer, this block writes zeros to every border location of the padded output tensor in the GLB.
- The mapper has already written the interior at offset (padding_num, padding_num). This block writes only the border, one word per accepted cycle. It then pulses padding_done so the next layer can start.

Parameters:
N_WIDTH, 2, batch-count width
M_WIDTH, 10, feature-map-count width
E_WIDTH, 6, height width (padded height must fit)
F_WIDTH, 6, width width (padded width must fit)
V_WIDTH, 2, padding-size width
ADDR_BUS_WIDTH, 20, GLB address width
DATA_WIDTH, 16, GLB data word width

Ports:
core_clk  in  1  clock; single clock domain
reset  in  1  synchronous, active-high reset
start_padding  in  1  start request; driven from mapper normalized_layer; sampled only in IDLE
dim4  in  N_WIDTH  batches N
dim3  in  M_WIDTH  feature maps M
dim2  in  E_WIDTH  unpadded height
dim1  in  F_WIDTH  unpadded width
padding_num  in  V_WIDTH  pad size p
w_ready  in  1  GLB accepts write this cycle
w_addr  out  ADDR_BUS_WIDTH  write address
w_data  out  DATA_WIDTH  write data; constant 0
w_enable  out  1  write request
busy  out  1  high in SETUP and WRITE
padding_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, any state): state=IDLE; w_addr=0, w_data=0, w_enable=0, busy=0, padding_done=0; all counters 0.
- Derived sizes: P2=dim2+2p, P1=dim1+2p (truncated to E/F widths), PLANE=P1*P2.
- Address, row-major (same as mapper write side): addr = (n*M + m)*PLANE + w*P2 + h, with w in [0,P1), h in [0,P2); truncated to ADDR_BUS_WIDTH.
- Address generation is incremental: plane_base += PLANE, col_base += P2. One multiplier only, for PLANE.
- Border test: h<p, or h>=dim2+p, or w<p, or w>=dim1+p.
- Scan order: h innermost, then w, then m, then n.
- Interior skip: in an interior column (p<=w<dim1+p), h jumps from p-1 directly to dim2+p, so every issued address is a border address and there are no idle bubbles.
- FSM IDLE: when start_padding=1, latch dims and p, then go to SETUP. Otherwise stay in IDLE.
- FSM SETUP (1 cycle): compute P1, P2, PLANE; clear counters.
  - If p==0, dim3==0 or dim4==0, go to DONE with no writes.
  - Otherwise go to WRITE.
- FSM WRITE: w_enable=1 with w_addr = current border address.
  - Advance only on w_enable && w_ready. If w_ready=0, w_addr and w_enable are held stable.
  - On acceptance of the last border word (n=N-1, m=M-1, w=P1-1, h=P2-1), drop w_enable next cycle and go to DONE.
- FSM DONE (1 cycle): padding_done=1, busy=0, then IDLE.
- Latency: start_padding sampled at edge k gives first w_enable in cycle k+2.
- Total writes = N*M*(PLANE - dim1*dim2). With w_ready tied high, done pulses 2+writes cycles after start.
- start_padding while not in IDLE is ignored. Dim inputs are ignored after latching.
- Reset mid-operation aborts immediately. No done pulse is produced and no further writes are issued.

Decomposition:
- Package lrn_pkg holds pad_state_t (IDLE, SETUP, WRITE, DONE) and PAD_ZERO = '0 of DATA_WIDTH.
- PLANE uses the existing unsigned_wallace_tree_multiplier (F_WIDTH x E_WIDTH). No DSP inference.
- Natural sub-module: lrn_pad_index_gen, holding the h/w/m/n counters, interior skip, bases and last flag. The top level holds the FSM and handshake.

Test Plan:
- N=1,M=1,dim2=2,dim1=2,p=1, w_ready=1 -> 12 writes at addresses 0,1,2,3,4,7,8,11,12,13,14,15, all data 0; padding_done in cycle 14 after start.
- N=2,M=3,dim2=dim1=4,p=2, w_ready=1 -> 6*(64-16)=288 writes. Every address satisfies the border test. The plane-1 base is 64 and the last address is 383.
- Same as test 1 with w_ready toggling 1,0,0,1,... -> each address is held unchanged while w_ready=0. Sequence is identical, with 12 accepted writes.
- p=0 (any dims) -> no w_enable; padding_done 2 cycles after start; busy high for 1 cycle.
- Reset asserted at the 5th write of test 1 -> next cycle all outputs 0 and state IDLE; a new start restarts from address 0.
- start_padding pulsed again during WRITE -> ignored; write count is unchanged and there is exactly one done pulse.
